phys_reg_reclaim_8wide: RTL and testbench
=========================================

// Module: phys_reg_reclaim_8wide
// PURPOSE
//  Retirement-side counterpart of the 8-wide rename stage. It accepts up to RETIRE_W retiring
//  instructions per cycle, updates the committed (architectural) rename map, and reclaims the
//  superseded physical registers (old_rd_phys). Reclaimed tags go into a circular buffer that
//  drains up to RELEASE_W tags per cycle back to the rename free list.
// PARAMETERS
//  PHYS_REGS  128 : number of physical registers (tag width = $clog2(PHYS_REGS) = 7)
//  ARCH_REGS  32  : number of architectural registers (index width = 5)
//  RETIRE_W   8   : retire lanes per cycle
//  RELEASE_W  4   : tags released to the free list per cycle
//  BUF_DEPTH  16  : reclaim buffer entries; power of two, >= RETIRE_W
// PORTS
//  clk               in   1              : clock; all state updates on the rising edge
//  rst_n             in   1              : synchronous, active-low reset
//  retire_valid_i    in   RETIRE_W       : per-lane retire valid
//  retire_has_rd_i   in   RETIRE_W       : lane writes a destination register
//  retire_rd_arch_i  in   5 x RETIRE_W   : architectural destination register
//  retire_rd_phys_i  in   7 x RETIRE_W   : physical tag now committed for rd
//  retire_old_phys_i in   7 x RETIRE_W   : previous mapping of rd, to be reclaimed
//  retire_ready_o    out  1              : buffer can absorb a full retire group
//  release_valid_o   out  RELEASE_W      : per-lane release valid
//  release_phys_o    out  7 x RELEASE_W  : tags being returned to the free list
//  release_ready_i   in   1              : free list accepts all valid release lanes this cycle
//  commit_map_o      out  7 x ARCH_REGS  : committed rename map, used for flush recovery
//  buf_count_o       out  5              : occupied reclaim buffer entries
//  dbl_free_o        out  1              : duplicate-reclaim error pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - commit_map[i] = i; head = tail = count = 0; dbl_free_o = 0.
//   - Buffer contents are discarded. Reset must coincide with the rename-stage reset, which
//     rebuilds the free list.
//  Ready and accept:
//   - retire_ready_o = (BUF_DEPTH - count >= RETIRE_W). This is combinational from registered
//     count and ignores same-cycle pops.
//   - A retire group is accepted when retire_ready_o=1. A group presented while
//     retire_ready_o=0 is ignored with no state change; upstream holds it.
//  Lane qualify: a lane commits iff valid && has_rd && rd_arch != 0. Unqualified lanes have no
//  effect.
//  Commit map: commit_map[rd_arch] <= rd_phys for each qualifying lane, processed lane 0..7.
//  When lanes share rd_arch, the highest lane wins.
//  Push:
//   - Qualifying old_phys values are compacted in lane order and written at tail, tail+1, ...
//   - Pointers wrap modulo BUF_DEPTH.
//  Release:
//   - release_valid_o[i] = (i < count).
//   - release_phys_o[i] = buf[(head+i) mod BUF_DEPTH]; unused lanes drive 0.
//   - When release_ready_i=1, pop n = min(count, RELEASE_W): head += n.
//  Latency: a tag pushed in cycle N is first visible on release_* in cycle N+1.
//  Simultaneous push and pop: count_next = count + pushes - pops. No bypass of a tag into the
//  same-cycle release.
//  Empty: release_valid_o = 0 and release_ready_i is don't-care.
//  Full: retire_ready_o deasserts whenever count > BUF_DEPTH - RETIRE_W, so the buffer never
//  overflows.
// CONFIGURATION
//  RECLAIM_DOUBLE_FREE_CHECK_EN defined:
//   - Keep a PHYS_REGS-bit pending bitmap: set on push, clear on pop.
//   - A push whose tag is already pending, or duplicated in an earlier lane of the same group,
//     is dropped (not pushed).
//   - dbl_free_o is registered high for 1 cycle in the cycle after the accepting edge.
//  Not defined: no bitmap; dbl_free_o is tied 0 and duplicates are pushed normally.
// TESTING
//  1. Reset: hold rst_n=0 for 1 cycle -> commit_map_o[5]=5, buf_count_o=0,
//     release_valid_o=0000, retire_ready_o=1.
//  2. Group with release_ready_i=0:
//     - Stimulus: lanes 0,2,5 retire rd_arch 1,2,3 / rd_phys 32,33,34 / old 1,2,3; lane 6 has
//       rd_arch=0; lane 7 has has_rd=0.
//     - Next cycle: commit_map 1..3 = 32,33,34; buf_count_o=3; release_valid_o=0111;
//       release_phys_o = 1,2,3; commit_map_o[0]=0.
//  3. Same arch, 2 lanes: rd_arch 7, phys 40 (old 7) then 41 (old 40)
//     -> commit_map_o[7]=41; buffer holds 7 then 40.
//  4. Backpressure:
//     - Push 9 tags with release_ready_i=0 -> retire_ready_o=0; a further group is ignored and
//       count stays 9.
//     - Pulse release_ready_i for 1 cycle -> count 5, retire_ready_o=1.
//  5. Wrap: 8 pushes/cycle alternating with 4 pops/cycle over 40 unique tags. Pointers cross
//     15->0; tags are released in exact push order, count never exceeds 16, none lost.
//  6. With RECLAIM_DOUBLE_FREE_CHECK_EN: reclaim tag 50 twice while pending
//     -> dbl_free_o pulses once; count increments by 1 only.

Source files
------------

// File: rtl/phys_reg_reclaim_8wide.sv
// phys_reg_reclaim_8wide: retire-side committed rename map plus a reclaim buffer that returns freed physical tags
//
// Each cycle, up to RETIRE_W retiring instructions update the committed (architectural)
// rename map. Each one also hands back the physical tag its destination register used to map
// to. Those freed tags are queued in a circular buffer. Up to RELEASE_W of them per cycle go
// back to the rename free list.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   retire_valid_i      per-lane retire valid
//   retire_has_rd_i     per-lane "writes a destination register"
//   retire_rd_arch_i    per-lane architectural destination (lane l at [l*AW +: AW])
//   retire_rd_phys_i    per-lane newly committed physical tag
//   retire_old_phys_i   per-lane superseded physical tag, to be reclaimed
//   retire_ready_o      buffer has room for a full retire group
//   release_valid_o     per-lane release valid
//   release_phys_o      per-lane released tag (lane i at [i*TW +: TW]), 0 when invalid
//   release_ready_i     free list takes every valid release lane this cycle
//   commit_map_o        committed map, entry r at [r*TW +: TW]
//   buf_count_o         occupied reclaim buffer entries
//   dbl_free_o          one-cycle pulse after a group in which a duplicate tag was dropped
//
// Optional feature: define RECLAIM_DOUBLE_FREE_CHECK_EN to track pending tags and drop
// duplicate reclaims. Without it, dbl_free_o is tied low and duplicates are queued as-is.
module phys_reg_reclaim_8wide #(
    parameter int PHYS_REGS = 128,
    parameter int ARCH_REGS = 32,
    parameter int RETIRE_W  = 8,
    parameter int RELEASE_W = 4,
    parameter int BUF_DEPTH = 16,
    localparam int TW = $clog2(PHYS_REGS),
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(BUF_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [RETIRE_W-1:0]       retire_valid_i,
    input  logic [RETIRE_W-1:0]       retire_has_rd_i,
    input  logic [RETIRE_W*AW-1:0]    retire_rd_arch_i,
    input  logic [RETIRE_W*TW-1:0]    retire_rd_phys_i,
    input  logic [RETIRE_W*TW-1:0]    retire_old_phys_i,
    output logic                      retire_ready_o,
    output logic [RELEASE_W-1:0]      release_valid_o,
    output logic [RELEASE_W*TW-1:0]   release_phys_o,
    input  logic                      release_ready_i,
    output logic [ARCH_REGS*TW-1:0]   commit_map_o,
    output logic [CW-1:0]             buf_count_o,
    output logic                      dbl_free_o
);
    logic [TW-1:0]       map_q [ARCH_REGS];
    logic [TW-1:0]       map_d [ARCH_REGS];
    logic [TW-1:0]       buf_q [BUF_DEPTH];
    logic [TW-1:0]       buf_d [BUF_DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d, n_push, n_pop;
    logic [RETIRE_W-1:0] qual, keep;

    // Readiness looks only at the registered count. A full group must fit even if nothing pops.
    assign retire_ready_o = count_q <= CW'(BUF_DEPTH - RETIRE_W);
    assign n_pop          = !release_ready_i ? '0 : (count_q < CW'(RELEASE_W) ? count_q : CW'(RELEASE_W));
    assign buf_count_o    = count_q;

    for (genvar l = 0; l < RETIRE_W; l++) begin : g_qual
        assign qual[l] = retire_valid_i[l] & retire_has_rd_i[l] & (retire_rd_arch_i[l*AW +: AW] != '0);
    end

    for (genvar i = 0; i < RELEASE_W; i++) begin : g_rel
        logic [PW-1:0] idx;
        assign idx                      = head_q + PW'(i);
        assign release_valid_o[i]       = CW'(i) < count_q;
        assign release_phys_o[i*TW +: TW] = release_valid_o[i] ? buf_q[idx] : '0;
    end

    for (genvar a = 0; a < ARCH_REGS; a++) begin : g_map
        assign commit_map_o[a*TW +: TW] = map_q[a];
    end

`ifdef RECLAIM_DOUBLE_FREE_CHECK_EN
    logic [PHYS_REGS-1:0] pend_q, pend_d, seen;
    logic                 dbl_q;
    // seen accumulates pending tags plus tags claimed by earlier lanes of this group, so a
    // repeat within the group is caught in the same way as a repeat of an already queued tag.
    always_comb begin
        seen = pend_q;
        keep = '0;
        for (int l = 0; l < RETIRE_W; l++) begin
            keep[l] = qual[l] && !seen[retire_old_phys_i[l*TW +: TW]];
            if (qual[l]) seen[retire_old_phys_i[l*TW +: TW]] = 1'b1;
        end
        pend_d = pend_q;
        for (int i = 0; i < RELEASE_W; i++)
            if (CW'(i) < n_pop) pend_d[release_phys_o[i*TW +: TW]] = 1'b0;
        if (retire_ready_o) pend_d = pend_d | (seen & ~pend_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            dbl_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dbl_q  <= retire_ready_o && (qual != keep);
        end
    end
    assign dbl_free_o = dbl_q;
`else
    assign keep       = qual;
    assign dbl_free_o = 1'b0;
`endif

    // Lanes are walked in order: the map's last writer wins, and kept tags pack densely from tail.
    always_comb begin
        map_d  = map_q;
        buf_d  = buf_q;
        n_push = '0;
        for (int l = 0; l < RETIRE_W; l++) begin
            if (retire_ready_o && qual[l]) map_d[retire_rd_arch_i[l*AW +: AW]] = retire_rd_phys_i[l*TW +: TW];
            if (retire_ready_o && keep[l]) begin
                buf_d[tail_q + n_push[PW-1:0]] = retire_old_phys_i[l*TW +: TW];
                n_push = n_push + CW'(1);
            end
        end
        count_d = count_q + n_push - n_pop;
        head_d  = head_q + n_pop[PW-1:0];
        tail_d  = tail_q + n_push[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= TW'(a);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            map_q   <= map_d;
        end
    end

    // Buffer contents need no reset: count gates every read.
    always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_phys_reg_reclaim_8wide.sv
// tb_phys_reg_reclaim_8wide: directed table plus corner-case sequences for the reclaim buffer
module tb_phys_reg_reclaim_8wide;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rv_i, hr_i;
    logic [39:0]  ra_i;
    logic [55:0]  rp_i, op_i;
    logic         rel_i;
    logic         rdy_o;
    logic [3:0]   relv_o;
    logic [27:0]  relp_o;
    logic [223:0] map_o;
    logic [4:0]   cnt_o;
    logic         dbl_o;
    int           nvec = 0;
    int           nerr = 0;

    always #5 clk = ~clk;

    phys_reg_reclaim_8wide dut (
        .clk(clk), .rst_n(rst_n),
        .retire_valid_i(rv_i), .retire_has_rd_i(hr_i), .retire_rd_arch_i(ra_i),
        .retire_rd_phys_i(rp_i), .retire_old_phys_i(op_i), .retire_ready_o(rdy_o),
        .release_valid_o(relv_o), .release_phys_o(relp_o), .release_ready_i(rel_i),
        .commit_map_o(map_o), .buf_count_o(cnt_o), .dbl_free_o(dbl_o)
    );

    typedef struct {
        logic [7:0]  v, h;
        logic [39:0] a;
        logic [55:0] p, o;
        logic        rel;
        logic [4:0]  cnt;
        logic        rdy;
        logic [3:0]  rv;
        logic [27:0] rp;
        int          mi;
        logic [6:0]  mv;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [55:0] p7(input int a0 = 0, a1 = 0, a2 = 0, a3 = 0, a4 = 0, a5 = 0, a6 = 0, a7 = 0);
        return {7'(a7), 7'(a6), 7'(a5), 7'(a4), 7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction
    function automatic logic [39:0] p5(input int a0 = 0, a1 = 0, a2 = 0, a3 = 0, a4 = 0, a5 = 0, a6 = 0, a7 = 0);
        return {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction
    function automatic logic [27:0] r4(input int a0 = 0, a1 = 0, a2 = 0, a3 = 0);
        return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction
    function automatic logic [31:0] mp(input int i);
        return 32'(map_o[i*7 +: 7]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rv_i = '0; hr_i = '0; ra_i = '0; rp_i = '0; op_i = '0;
    endtask

    int q[$];
    int nt;
    int cyc;
    logic push;
    int c0;

    initial begin
        tbl[0] = '{v: 8'b1110_0101, h: 8'b0110_0101, a: p5(1, 0, 2, 0, 0, 3, 0, 4),
                   p: p7(32, 0, 33, 0, 0, 34, 60, 61), o: p7(1, 0, 2, 0, 0, 3, 62, 63),
                   rel: 1'b0, cnt: 5'd3, rdy: 1'b1, rv: 4'b0111, rp: r4(1, 2, 3, 0), mi: 2, mv: 7'd33};
        tbl[1] = '{v: 8'h03, h: 8'h03, a: p5(7, 7), p: p7(40, 41), o: p7(7, 40),
                   rel: 1'b0, cnt: 5'd5, rdy: 1'b1, rv: 4'b1111, rp: r4(1, 2, 3, 7), mi: 7, mv: 7'd41};
        tbl[2] = '{v: 8'h00, h: 8'h00, a: '0, p: '0, o: '0,
                   rel: 1'b1, cnt: 5'd1, rdy: 1'b1, rv: 4'b0001, rp: r4(40), mi: 3, mv: 7'd34};
        tbl[3] = '{v: 8'h00, h: 8'h00, a: '0, p: '0, o: '0,
                   rel: 1'b1, cnt: 5'd0, rdy: 1'b1, rv: 4'b0000, rp: '0, mi: 1, mv: 7'd32};
        tbl[4] = '{v: 8'h01, h: 8'h01, a: p5(0), p: p7(99), o: p7(98),
                   rel: 1'b1, cnt: 5'd0, rdy: 1'b1, rv: 4'b0000, rp: '0, mi: 0, mv: 7'd0};

        rst_n = 1'b0; rel_i = 1'b0; idle();
        step;
        rst_n = 1'b1;
        chk("rst_map5", mp(5), 32'd5);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_relv", 32'(relv_o), 32'd0);
        chk("rst_rdy", 32'(rdy_o), 32'd1);
        chk("rst_dbl", 32'(dbl_o), 32'd0);

        for (int k = 0; k < 5; k++) begin
            rv_i = tbl[k].v; hr_i = tbl[k].h; ra_i = tbl[k].a;
            rp_i = tbl[k].p; op_i = tbl[k].o; rel_i = tbl[k].rel;
            step;
            chk($sformatf("v%0d_cnt", k), 32'(cnt_o), 32'(tbl[k].cnt));
            chk($sformatf("v%0d_rdy", k), 32'(rdy_o), 32'(tbl[k].rdy));
            chk($sformatf("v%0d_relv", k), 32'(relv_o), 32'(tbl[k].rv));
            chk($sformatf("v%0d_relp", k), 32'(relp_o), 32'(tbl[k].rp));
            chk($sformatf("v%0d_map", k), mp(tbl[k].mi), 32'(tbl[k].mv));
        end
        chk("map0_after", mp(0), 32'd0);
        chk("map1_after", mp(1), 32'd32);
        chk("map3_after", mp(3), 32'd34);
        chk("map4_no_rd", mp(4), 32'd4);
        chk("map7_after", mp(7), 32'd41);

        // Backpressure: 9 queued tags block the next group until one pop.
        rel_i = 1'b0;
        rv_i = 8'hff; hr_i = 8'hff; ra_i = p5(8, 9, 10, 11, 12, 13, 14, 15);
        rp_i = p7(90, 91, 92, 93, 94, 95, 96, 97); op_i = p7(64, 65, 66, 67, 68, 69, 70, 71);
        step;
        chk("bp_cnt8", 32'(cnt_o), 32'd8);
        chk("bp_rdy8", 32'(rdy_o), 32'd1);
        rv_i = 8'h01; ra_i = p5(16); rp_i = p7(98); op_i = p7(72);
        step;
        chk("bp_cnt9", 32'(cnt_o), 32'd9);
        chk("bp_rdy9", 32'(rdy_o), 32'd0);
        rv_i = 8'hff; ra_i = p5(17, 18, 19, 20, 21, 22, 23, 24);
        rp_i = p7(100, 101, 102, 103, 104, 105, 106, 107); op_i = p7(80, 81, 82, 83, 84, 85, 86, 87);
        step;
        chk("bp_ignored_cnt", 32'(cnt_o), 32'd9);
        chk("bp_ignored_map", mp(17), 32'd17);
        idle(); rel_i = 1'b1;
        step;
        chk("bp_pop_cnt", 32'(cnt_o), 32'd5);
        chk("bp_pop_rdy", 32'(rdy_o), 32'd1);
        chk("bp_pop_relp", 32'(relp_o), 32'(r4(68, 69, 70, 71)));
        step;
        chk("bp_pop2_cnt", 32'(cnt_o), 32'd1);
        chk("bp_pop2_relp", 32'(relp_o), 32'(r4(72)));
        step;
        chk("bp_drained", 32'(cnt_o), 32'd0);

        // Wrap: alternate push-8 / pop-4 over 40 unique tags against a queue model.
        nt = 10; cyc = 0;
        while ((nt < 50 || q.size() != 0) && cyc < 200) begin
            push = (cyc % 2 == 0) && q.size() <= 8 && nt < 50;
            rel_i = (cyc % 2 == 1);
            rv_i = push ? 8'hff : 8'h00; hr_i = 8'hff;
            ra_i = p5(1, 2, 3, 4, 5, 6, 7, 8);
            rp_i = p7(110, 111, 112, 113, 114, 115, 116, 117);
            op_i = p7(nt, nt + 1, nt + 2, nt + 3, nt + 4, nt + 5, nt + 6, nt + 7);
            step;
            if (rel_i) for (int n = 0; n < 4 && q.size() != 0; n++) void'(q.pop_front());
            if (push) begin
                for (int l = 0; l < 8; l++) q.push_back(nt + l);
                nt += 8;
            end
            chk("wrap_cnt", 32'(cnt_o), 32'(q.size()));
            chk("wrap_rdy", 32'(rdy_o), 32'(q.size() <= 8));
            for (int i = 0; i < 4; i++) begin
                chk("wrap_relv", 32'(relv_o[i]), 32'(i < q.size()));
                chk("wrap_relp", 32'(relp_o[i*7 +: 7]), 32'(i < q.size() ? q[i] : 0));
            end
            cyc++;
        end
        if (cyc >= 200) begin
            nerr++;
            $display("FAIL wrap_timeout: %0d cycles, %0d tags left", cyc, q.size());
        end

        // Duplicate reclaim of tag 50.
        rel_i = 1'b0; idle();
        c0 = 32'(cnt_o);
        rv_i = 8'h03; hr_i = 8'h03; ra_i = p5(5, 6); rp_i = p7(120, 121); op_i = p7(50, 50);
        step;
`ifdef RECLAIM_DOUBLE_FREE_CHECK_EN
        chk("dup_grp_cnt", 32'(cnt_o), 32'(c0 + 1));
        chk("dup_grp_dbl", 32'(dbl_o), 32'd1);
`else
        chk("dup_grp_cnt", 32'(cnt_o), 32'(c0 + 2));
        chk("dup_grp_dbl", 32'(dbl_o), 32'd0);
`endif
        rv_i = 8'h01; ra_i = p5(5); rp_i = p7(122); op_i = p7(50);
        step;
`ifdef RECLAIM_DOUBLE_FREE_CHECK_EN
        chk("dup_pend_cnt", 32'(cnt_o), 32'(c0 + 1));
        chk("dup_pend_dbl", 32'(dbl_o), 32'd1);
`else
        chk("dup_pend_cnt", 32'(cnt_o), 32'(c0 + 3));
        chk("dup_pend_dbl", 32'(dbl_o), 32'd0);
`endif
        idle();
        step;
        chk("dup_dbl_clear", 32'(dbl_o), 32'd0);
        chk("dup_relp0", 32'(relp_o[6:0]), 32'd50);
        rel_i = 1'b1;
        step;
        chk("dup_popped", 32'(cnt_o), 32'd0);
        rel_i = 1'b0;
        rv_i = 8'h01; hr_i = 8'h01; ra_i = p5(5); rp_i = p7(123); op_i = p7(50);
        step;
        idle();
        chk("reuse_cnt", 32'(cnt_o), 32'd1);
        chk("reuse_dbl", 32'(dbl_o), 32'd0);
        chk("reuse_relp0", 32'(relp_o[6:0]), 32'd50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
